jtpopeye_objdma: RTL and testbench

JTPOPEYE_OBJDMA -- requirements
Module: jtpopeye_objdma

---
 rtl/jtpopeye_objdma.sv | 152 +++++++++++++++
 tb/tb_jtpopeye_objdma.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_objdma.sv
// Copies one 256-byte page of CPU work RAM into the object buffer during vertical blank.
// Define JTPOPEYE_OBJDMA_DBLBUF_EN for a double-buffered object buffer (bank flips after each complete copy).
module jtpopeye_objdma (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pxl2_cen,
    input  logic       VB,
    input  logic       dma_req,
    input  logic [1:0] src_page,
    input  logic       busak_n,
    output logic       busrq_n,
    output logic [9:0] ram_addr,
    input  logic [7:0] ram_din,
    output logic [8:0] obj_addr,
    output logic [7:0] obj_dout,
    output logic       obj_we,
    output logic       busy,
    output logic       obj_bank,
    output logic       overrun
);
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned PAGE_W = 2;

    typedef enum logic [2:0] {IDLE, ARM, REQ, COPY, FLUSH, RELEASE} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_prev;
    logic [PAGE_W-1:0]   page, pend_page;
    logic                pending;
    logic                vb_last;
    logic                wr_bank;
    logic                accept_c, issue_c, write_c, abort_c, done_c;

    assign idx_prev = idx - IDX_W'(1);

`ifdef JTPOPEYE_OBJDMA_DBLBUF_EN
    assign wr_bank = ~obj_bank;
`else
    assign wr_bank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        state <= IDLE;
        else if (pxl2_cen) state <= state_nxt;
    end

    // Next state and per-cen control strobes; the read pipeline writes idx-1 while issuing idx
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        issue_c   = 1'b0;
        write_c   = 1'b0;
        abort_c   = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: if (dma_req) begin
                accept_c  = 1'b1;
                state_nxt = ARM;
            end
            ARM: if (VB && !vb_last) state_nxt = REQ;
            REQ: begin
                if (!VB) begin
                    abort_c   = 1'b1;
                    state_nxt = RELEASE;
                end else if (!busak_n) begin
                    state_nxt = COPY;
                end
            end
            COPY: begin
                if (!VB) begin
                    abort_c   = 1'b1;
                    state_nxt = RELEASE;
                end else if (!busak_n) begin
                    issue_c = 1'b1;
                    write_c = (idx != '0);
                    if (idx == '1) state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                write_c   = 1'b1;
                done_c    = 1'b1;
                state_nxt = RELEASE;
            end
            RELEASE: begin
                if (pending || dma_req) begin
                    accept_c  = 1'b1;
                    state_nxt = ARM;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs; obj_we is the only output allowed to drop between cens
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            page      <= '0;
            pend_page <= '0;
            pending   <= 1'b0;
            vb_last   <= 1'b0;
            busrq_n   <= 1'b1;
            ram_addr  <= '0;
            obj_addr  <= '0;
            obj_dout  <= '0;
            obj_we    <= 1'b0;
            busy      <= 1'b0;
            obj_bank  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            obj_we <= 1'b0;
            if (pxl2_cen) begin
                vb_last <= VB;
                busrq_n <= !(state_nxt inside {REQ, COPY, FLUSH});
                busy    <= (state_nxt != IDLE);

                if (accept_c) begin
                    page    <= dma_req ? src_page : pend_page;
                    idx     <= '0;
                    overrun <= 1'b0;
                    pending <= 1'b0;
                end else if (dma_req) begin
                    pending   <= 1'b1;
                    pend_page <= src_page;
                end

                if (abort_c) overrun <= 1'b1;

                if (issue_c) begin
                    ram_addr <= {page, idx};
                    idx      <= idx + IDX_W'(1);
                end

                if (write_c) begin
                    obj_addr <= {wr_bank, idx_prev};
                    obj_dout <= ram_din;
                    obj_we   <= 1'b1;
                end

`ifdef JTPOPEYE_OBJDMA_DBLBUF_EN
                if (done_c) obj_bank <= ~obj_bank;
`else
                obj_bank <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_jtpopeye_objdma.sv
// Scoreboard bench for jtpopeye_objdma: expected object-buffer writes are queued per transfer and
// popped as obj_we pulses appear. Honours JTPOPEYE_OBJDMA_DBLBUF_EN for the bank model.
module tb_jtpopeye_objdma;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pxl2_cen = 1'b0;
    logic       VB = 1'b0;
    logic       dma_req = 1'b0;
    logic [1:0] src_page = 2'd0;
    logic       busak_n = 1'b1;
    logic       busrq_n;
    logic [9:0] ram_addr;
    logic [7:0] ram_din;
    logic [8:0] obj_addr;
    logic [7:0] obj_dout;
    logic       obj_we;
    logic       busy;
    logic       obj_bank;
    logic       overrun;

    typedef struct packed {
        logic [8:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem [0:1023];
    int         checks = 0;
    int         errors = 0;
    int         wr_cnt = 0;
    int         ack_cnt = 0;
    logic       stall = 1'b0;
    logic       bank_m = 1'b0;

    jtpopeye_objdma dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pxl2_cen (pxl2_cen),
        .VB       (VB),
        .dma_req  (dma_req),
        .src_page (src_page),
        .busak_n  (busak_n),
        .busrq_n  (busrq_n),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .obj_addr (obj_addr),
        .obj_dout (obj_dout),
        .obj_we   (obj_we),
        .busy     (busy),
        .obj_bank (obj_bank),
        .overrun  (overrun)
    );

    assign ram_din = mem[ram_addr];

    // Clock with a cen on every other rising edge; cen changes well away from either edge
    initial begin
        forever begin
            #5 clk = 1'b1;
            #2 pxl2_cen = ~pxl2_cen;
            #3 clk = 1'b0;
        end
    end

    // Z80 bus model: grants two cycles after the request, stall forces the grant away
    always @(negedge clk) begin
        if (busrq_n) begin
            busak_n = 1'b1;
            ack_cnt = 0;
        end else if (ack_cnt < 2) begin
            ack_cnt++;
        end else begin
            busak_n = stall;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (obj_we) begin
            if (exp_q.size() == 0) begin
                check("extra_wr", 32'(obj_addr), 32'h1ff);
            end else begin
                e = exp_q.pop_front();
                check("obj_addr", 32'(obj_addr), 32'(e.addr));
                check("obj_dout", 32'(obj_dout), 32'(e.data));
            end
            wr_cnt++;
        end
    end

    function automatic logic wbank();
`ifdef JTPOPEYE_OBJDMA_DBLBUF_EN
        return ~bank_m;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic flip(input logic b);
`ifdef JTPOPEYE_OBJDMA_DBLBUF_EN
        return ~b;
`else
        return b;
`endif
    endfunction

    task automatic cen_edge();
        do @(posedge clk); while (!pxl2_cen);
        #1;
    endtask

    task automatic pulse_req(input logic [1:0] pg);
        src_page = pg;
        dma_req  = 1'b1;
        cen_edge();
        dma_req  = 1'b0;
    endtask

    task automatic push_copy(input logic [1:0] pg, input logic bk, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = {bk, 8'(i)};
            e.data = mem[{pg, 8'(i)}];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_busrq(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (busrq_n !== lvl && n < budget) begin
            cen_edge();
            n++;
        end
        check(tag, 32'(busrq_n), 32'(lvl));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            cen_edge();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_wr(input int cnt, input int budget, input string tag);
        int n = 0;
        while (wr_cnt < cnt && n < budget) begin
            cen_edge();
            n++;
        end
        check(tag, 32'(wr_cnt >= cnt), 32'd1);
    endtask

    task automatic wait_idx(input logic [7:0] ix, input int budget, input string tag);
        int n = 0;
        while (!(obj_we && obj_addr[7:0] == ix) && n < budget) begin
            cen_edge();
            n++;
        end
        check(tag, 32'(obj_we), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);

        // Reset values while held in reset
        #23;
        check("rst_busrq_n", 32'(busrq_n), 32'd1);
        check("rst_obj_we", 32'(obj_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_obj_bank", 32'(obj_bank), 32'd0);
        rst_n = 1'b1;
        repeat (3) cen_edge();

        // VB edges without a request are ignored
        VB = 1'b1;
        repeat (5) cen_edge();
        VB = 1'b0;
        repeat (3) cen_edge();
        check("idle_vb_busrq", 32'(busrq_n), 32'd1);
        check("idle_vb_busy", 32'(busy), 32'd0);

        // Full copy of page 2 with a bus stall in the middle
        wr_cnt = 0;
        pulse_req(2'd2);
        check("t1_busy", 32'(busy), 32'd1);
        push_copy(2'd2, wbank(), 256);
        repeat (3) cen_edge();
        check("t1_arm_busrq", 32'(busrq_n), 32'd1);
        VB = 1'b1;
        wait_busrq(1'b0, 10, "t1_busrq_low");
        wait_wr(30, 100, "t1_wr30");
        stall = 1'b1;
        cen_edge();
        cen_edge();
        saved = wr_cnt;
        repeat (8) cen_edge();
        check("t1_stall_wr", 32'(wr_cnt), 32'(saved));
        stall = 1'b0;
        wait_busrq(1'b1, 600, "t1_release_busrq");
        check("t1_release_busy", 32'(busy), 32'd1);
        wait_idle(5, "t1_idle");
        bank_m = flip(bank_m);
        check("t1_count", 32'(wr_cnt), 32'd256);
        check("t1_queue", 32'(exp_q.size()), 32'd0);
        check("t1_overrun", 32'(overrun), 32'd0);
        check("t1_bank", 32'(obj_bank), 32'(bank_m));
        VB = 1'b0;
        repeat (3) cen_edge();

        // Request while VB already high waits for the next rising edge
        wr_cnt = 0;
        VB = 1'b1;
        repeat (3) cen_edge();
        pulse_req(2'd3);
        repeat (20) cen_edge();
        check("t2_wait_busrq", 32'(busrq_n), 32'd1);
        check("t2_wait_busy", 32'(busy), 32'd1);
        VB = 1'b0;
        repeat (3) cen_edge();
        push_copy(2'd3, wbank(), 256);
        VB = 1'b1;
        wait_busrq(1'b0, 10, "t2_busrq_low");
        wait_idle(600, "t2_idle");
        bank_m = flip(bank_m);
        check("t2_count", 32'(wr_cnt), 32'd256);
        check("t2_queue", 32'(exp_q.size()), 32'd0);
        check("t2_bank", 32'(obj_bank), 32'(bank_m));
        VB = 1'b0;
        repeat (3) cen_edge();

        // VB falls after 100 writes: abort, overrun, bank untouched
        wr_cnt = 0;
        pulse_req(2'd1);
        push_copy(2'd1, wbank(), 100);
        VB = 1'b1;
        wait_idx(8'd99, 600, "t3_idx99");
        VB = 1'b0;
        cen_edge();
        check("t3_overrun", 32'(overrun), 32'd1);
        check("t3_busrq_n", 32'(busrq_n), 32'd1);
        cen_edge();
        check("t3_busy", 32'(busy), 32'd0);
        repeat (5) cen_edge();
        check("t3_count", 32'(wr_cnt), 32'd100);
        check("t3_queue", 32'(exp_q.size()), 32'd0);
        check("t3_bank", 32'(obj_bank), 32'(bank_m));

        // Two requests during COPY merge into exactly one extra transfer
        wr_cnt = 0;
        pulse_req(2'd0);
        check("t4_overrun_clr", 32'(overrun), 32'd0);
        push_copy(2'd0, wbank(), 256);
        VB = 1'b1;
        wait_wr(10, 100, "t4_wr10");
        pulse_req(2'd1);
        repeat (3) cen_edge();
        pulse_req(2'd1);
        wait_busrq(1'b1, 600, "t4_first_done");
        bank_m = flip(bank_m);
        check("t4_pend_busy", 32'(busy), 32'd1);
        repeat (10) cen_edge();
        check("t4_pend_wait", 32'(busrq_n), 32'd1);
        check("t4_first_count", 32'(wr_cnt), 32'd256);
        VB = 1'b0;
        repeat (3) cen_edge();
        push_copy(2'd1, wbank(), 256);
        VB = 1'b1;
        wait_busrq(1'b0, 10, "t4_second_req");
        wait_idle(600, "t4_idle");
        bank_m = flip(bank_m);
        check("t4_count", 32'(wr_cnt), 32'd512);
        check("t4_queue", 32'(exp_q.size()), 32'd0);
        check("t4_bank", 32'(obj_bank), 32'(bank_m));
        VB = 1'b0;
        repeat (3) cen_edge();
        VB = 1'b1;
        repeat (10) cen_edge();
        check("t4_no_third_busrq", 32'(busrq_n), 32'd1);
        check("t4_no_third_busy", 32'(busy), 32'd0);
        VB = 1'b0;
        repeat (3) cen_edge();

        // Reset at index 50 kills the transfer within the same clk
        wr_cnt = 0;
        pulse_req(2'd2);
        push_copy(2'd2, wbank(), 256);
        VB = 1'b1;
        wait_idx(8'd50, 600, "t5_idx50");
        rst_n = 1'b0;
        #1;
        check("t5_busrq_n", 32'(busrq_n), 32'd1);
        check("t5_obj_we", 32'(obj_we), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_overrun", 32'(overrun), 32'd0);
        check("t5_obj_bank", 32'(obj_bank), 32'd0);
        exp_q.delete();
        bank_m = 1'b0;
        saved = wr_cnt;
        #20;
        rst_n = 1'b1;
        VB = 1'b0;
        repeat (3) cen_edge();
        VB = 1'b1;
        repeat (10) cen_edge();
        check("t5_post_busrq", 32'(busrq_n), 32'd1);
        check("t5_post_busy", 32'(busy), 32'd0);
        check("t5_no_writes", 32'(wr_cnt), 32'(saved));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
